fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the fixed PC register plus single IF/ID register with a PC generator, a request/grant instruction-memory port tolerating variable latency, and a DEPTH-entry in-order fetch queue. It decouples decode stalls from fetch and discards stale responses on EX-stage redirects.

---
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue.sv | 75 +++++++
 tb/tb_fetch_queue.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, instruction-memory and decode-side signals of the fetch front end.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;
  logic            deq_valid_o;
  logic            deq_ready_i;
  logic [31:0]     deq_instr_o;
  logic [XLEN-1:0] deq_pc_o;
  logic [XLEN-1:0] deq_pc_plus4_o;
  logic [CW-1:0]   count_o;
  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, deq_ready_i,
    output imem_req_o, imem_addr_o, deq_valid_o, deq_instr_o, deq_pc_o, deq_pc_plus4_o, count_o
  );
  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, deq_ready_i,
    input  imem_req_o, imem_addr_o, deq_valid_o, deq_instr_o, deq_pc_o, deq_pc_plus4_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC generator, variable-latency imem request port and in-order fetch queue
// that discards responses belonging to requests issued before an EX redirect.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [AW-1:0]   head, alloc, fill;
  logic [CW-1:0]   allocated, pending, drop_cnt;
  logic [CW:0]     occ;
  logic            grant, resp, deq;
  // dropped-but-outstanding responses still occupy memory-side slots
  assign occ                = {1'b0, allocated} + {1'b0, drop_cnt};
  assign bus.imem_req_o     = ~reset & ~bus.redirect_i & (occ < (CW+1)'(DEPTH));
  assign bus.imem_addr_o    = fpc;
  assign grant              = bus.imem_req_o & bus.imem_gnt_i;
  assign resp               = bus.imem_rvalid_i & (drop_cnt == '0) & ~bus.redirect_i;
  assign bus.deq_valid_o    = filled[head] & ~bus.redirect_i;
  assign deq                = bus.deq_valid_o & bus.deq_ready_i;
  assign bus.deq_instr_o    = instr_q[head];
  assign bus.deq_pc_o       = pc_q[head];
  assign bus.deq_pc_plus4_o = pc_q[head] + XLEN'(4);
  assign bus.count_o        = allocated;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc       <= RESET_PC;
      filled    <= '0;
      head      <= '0;
      alloc     <= '0;
      fill      <= '0;
      allocated <= '0;
      pending   <= '0;
      drop_cnt  <= '0;
    end else if (bus.redirect_i) begin
      fpc       <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
      filled    <= '0;
      head      <= '0;
      alloc     <= '0;
      fill      <= '0;
      allocated <= '0;
      pending   <= '0;
      drop_cnt  <= drop_cnt + pending - CW'(bus.imem_rvalid_i);
    end else begin
      if (grant) begin
        fpc   <= fpc + XLEN'(4);
        alloc <= alloc + 1'b1;
      end
      if (bus.imem_rvalid_i && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      if (resp) begin
        filled[fill] <= 1'b1;
        fill         <= fill + 1'b1;
      end
      if (deq) begin
        filled[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      allocated <= allocated + CW'(grant) - CW'(deq);
      pending   <= pending + CW'(grant) - CW'(resp);
    end
  end
  always_ff @(posedge clk) begin
    if (grant) pc_q[alloc] <= fpc;
    if (resp) instr_q[fill] <= bus.imem_rdata_i;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random fetch traffic against a queue-level reference model and an in-order memory model.
module tb_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  typedef struct { logic [31:0] pc; logic filled; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .reset(reset), .bus(bus));
  ent_t        q[$];
  mreq_t       mq[$];
  logic [31:0] fpc;
  int          drop, cyc, tests, failed, dut_deq;
  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask
  task automatic model_reset();
    q.delete();
    mq.delete();
    fpc  = RESET_PC;
    drop = 0;
  endtask
  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req"}, 32'(bus.imem_req_o), 32'd0);
    chk({tag, "_addr"}, bus.imem_addr_o, RESET_PC);
    chk({tag, "_valid"}, 32'(bus.deq_valid_o), 32'd0);
    chk({tag, "_count"}, 32'(bus.count_o), 32'd0);
  endtask
  task automatic step(int p_gnt, int p_rdy, int p_redir, int max_lat);
    logic        r, g, rv, rdy, e_req, e_val;
    logic [31:0] tgt;
    int          unf;
    @(negedge clk);
    r   = $urandom_range(99) < p_redir;
    tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
    g   = $urandom_range(99) < p_gnt;
    rdy = $urandom_range(99) < p_rdy;
    rv  = mq.size() > 0 && mq[0].due <= cyc;
    bus.redirect_i    = r;
    bus.redirect_pc_i = tgt;
    bus.imem_gnt_i    = g;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rv ? instr_of(mq[0].addr) : $urandom;
    bus.deq_ready_i   = rdy;
    #1;
    e_req = !r && (q.size() + drop < DEPTH);
    e_val = !r && q.size() > 0 && q[0].filled;
    chk("req", 32'(bus.imem_req_o), 32'(e_req));
    chk("addr", bus.imem_addr_o, fpc);
    chk("valid", 32'(bus.deq_valid_o), 32'(e_val));
    chk("count", 32'(bus.count_o), 32'(q.size()));
    if (e_val) begin
      chk("instr", bus.deq_instr_o, instr_of(q[0].pc));
      chk("pc", bus.deq_pc_o, q[0].pc);
      chk("pc_plus4", bus.deq_pc_plus4_o, q[0].pc + 32'd4);
    end
    if (bus.deq_valid_o && rdy) dut_deq++;
    if (rv) void'(mq.pop_front());
    if (r) begin
      unf = 0;
      foreach (q[i]) if (!q[i].filled) unf++;
      drop = drop + unf - int'(rv);
      q.delete();
      fpc = tgt & ~32'd3;
    end else begin
      if (rv) begin
        if (drop > 0) drop--;
        else
          for (int i = 0; i < q.size(); i++)
            if (!q[i].filled) begin
              q[i].filled = 1'b1;
              break;
            end
      end
      if (e_val && rdy) void'(q.pop_front());
      if (e_req && g) begin
        q.push_back('{pc: fpc, filled: 1'b0});
        mq.push_back('{addr: fpc, due: cyc + int'($urandom_range(max_lat, 1))});
        fpc = fpc + 32'd4;
      end
    end
    cyc++;
  endtask
  task automatic run(int n, int p_gnt, int p_rdy, int p_redir, int max_lat);
    for (int i = 0; i < n; i++) step(p_gnt, p_rdy, p_redir, max_lat);
  endtask
  initial begin
    tests = 0;
    failed = 0;
    cyc = 0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0;
    bus.deq_ready_i = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #1 chk_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    dut_deq = 0;
    run(30, 100, 100, 0, 1);
    chk("throughput", 32'(dut_deq), 32'd28);
    run(8, 100, 0, 0, 1);
    chk("full_count", 32'(bus.count_o), 32'(DEPTH));
    chk("full_req", 32'(bus.imem_req_o), 32'd0);
    run(20, 100, 100, 0, 1);
    run(60, 25, 60, 0, 3);
    run(400, 70, 70, 8, 3);
    run(200, 100, 100, 15, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    run(300, 60, 50, 5, 3);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
